// File: rtl/ldpc_serial_port.sv
// ldpc_serial_port
// Serial load/unload port for a bank of CH codeword buffers, each NN bits wide.
// An external agent moves a contiguous run of bits between a pin and one buffer
// (one bit per strobe). The decoder core reads any buffer combinationally and
// may overwrite a whole buffer, except the one a serial frame is using.
//
// Ports
//   wb_clk_i, wb_rst_n_i            clock, async active-low reset
//   P_start, P_inputnoutput         frame request and mode (1 = load, 0 = unload)
//   P_in_out_sel, P_len, P_chan     start bit, bit count, channel of the request
//   P_strobe, P_input               bit qualifier and serial load data
//   PO_output                       registered serial unload data
//   PO_busy, PO_done, PO_err        frame active / frame complete / request rejected
//   core_wr_en/_chan/_data, core_wr_ready   parallel buffer write from the core
//   core_rd_chan, core_rd_data      combinational buffer read
//   buf_valid, core_ack             per-channel "loaded, awaiting core" flag and its clear
module ldpc_serial_port #(
    parameter int  NN    = 208,
    parameter int  CH    = 2,
    parameter int  SEL_W = 16,
    localparam int CW    = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_n_i,
    input  logic             P_start,
    input  logic             P_inputnoutput,
    input  logic [SEL_W-1:0] P_in_out_sel,
    input  logic [SEL_W-1:0] P_len,
    input  logic [CW-1:0]    P_chan,
    input  logic             P_strobe,
    input  logic             P_input,
    output logic             PO_output,
    output logic             PO_busy,
    output logic             PO_done,
    output logic             PO_err,
    input  logic             core_wr_en,
    input  logic [CW-1:0]    core_wr_chan,
    input  logic [NN-1:0]    core_wr_data,
    output logic             core_wr_ready,
    input  logic [CW-1:0]    core_rd_chan,
    output logic [NN-1:0]    core_rd_data,
    output logic [CH-1:0]    buf_valid,
    input  logic [CH-1:0]    core_ack
);

    localparam int             IW     = (NN > 1) ? $clog2(NN) : 1;
    localparam logic [SEL_W-1:0] ONE  = SEL_W'(1);
    localparam logic [SEL_W:0]   NN_L = (SEL_W+1)'(NN);
    localparam logic [CW:0]      CH_L = (CW+1)'(CH);

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_UNLOAD, ST_DONE} state_t;

    state_t           state_q, state_d;
    logic             mode_q, mode_d;       // 1 = load frame
    logic [CW-1:0]    chan_q, chan_d;
    logic [SEL_W-1:0] index_q, index_d;
    logic [SEL_W-1:0] count_q, count_d;
    logic             err_q, err_d;
    logic             out_q, out_d;

    logic [NN-1:0]    buf_view [CH];
    logic [NN-1:0]    active_buf;
    logic [IW-1:0]    bit_idx;
    logic [SEL_W:0]   end_pos;
    logic             req_bad;

    // Accepted frames never address past NN-1, so the low bits suffice.
    assign bit_idx    = index_q[IW-1:0];
    assign active_buf = buf_view[chan_q];

    // Range check is done one bit wider so sel+len cannot wrap.
    assign end_pos = {1'b0, P_in_out_sel} + {1'b0, P_len};
    assign req_bad = (P_len == '0) || (end_pos > NN_L) || ({1'b0, P_chan} >= CH_L);

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        chan_d  = chan_q;
        index_d = index_q;
        count_d = count_q;
        err_d   = 1'b0;
        out_d   = out_q;
        case (state_q)
            ST_IDLE: begin
                if (P_start) begin
                    if (req_bad) begin
                        err_d = 1'b1;
                    end else begin
                        mode_d  = P_inputnoutput;
                        chan_d  = P_chan;
                        index_d = P_in_out_sel;
                        count_d = P_len;
                        state_d = P_inputnoutput ? ST_LOAD : ST_UNLOAD;
                    end
                end
            end
            ST_LOAD, ST_UNLOAD: begin
                err_d = P_start;
                if (P_strobe) begin
                    index_d = index_q + ONE;
                    count_d = count_q - ONE;
                    if (state_q == ST_UNLOAD) begin
                        out_d = active_buf[bit_idx];
                    end
                    if (count_q == ONE) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                err_d   = P_start;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q <= ST_IDLE;
            mode_q  <= 1'b0;
            chan_q  <= '0;
            index_q <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
            out_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            chan_q  <= chan_d;
            index_q <= index_d;
            count_q <= count_d;
            err_q   <= err_d;
            out_q   <= out_d;
        end
    end

    assign PO_busy   = (state_q == ST_LOAD) || (state_q == ST_UNLOAD);
    assign PO_done   = (state_q == ST_DONE);
    assign PO_err    = err_q;
    assign PO_output = out_q;

    // The channel owned by a running frame is locked against core writes.
    assign core_wr_ready = !(PO_busy && (core_wr_chan == chan_q));
    assign core_rd_data  = buf_view[core_rd_chan];

    for (genvar gi = 0; gi < CH; gi++) begin : g_chan
        logic [NN-1:0] data_q;
        logic          valid_q;
        logic          wr_hit, ld_hit, set_valid;

        assign wr_hit    = core_wr_en && core_wr_ready && (core_wr_chan == CW'(gi));
        assign ld_hit    = (state_q == ST_LOAD) && P_strobe && (chan_q == CW'(gi));
        assign set_valid = (state_q == ST_DONE) && mode_q && (chan_q == CW'(gi));

        always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
            if (!wb_rst_n_i) begin
                data_q  <= '0;
                valid_q <= 1'b0;
            end else begin
                // wr_hit and ld_hit are mutually exclusive through core_wr_ready.
                if (wr_hit) begin
                    data_q <= core_wr_data;
                end else if (ld_hit) begin
                    data_q[bit_idx] <= P_input;
                end
                // Completion of a load outranks a same-cycle acknowledge.
                if (set_valid) begin
                    valid_q <= 1'b1;
                end else if (core_ack[gi]) begin
                    valid_q <= 1'b0;
                end
            end
        end

        assign buf_view[gi]  = data_q;
        assign buf_valid[gi] = valid_q;
    end

endmodule

// File: tb/tb_ldpc_serial_port.sv
// Randomized scoreboard bench for ldpc_serial_port. The driver updates a
// behavioural buffer model and queues expected done/err pulses and unload bits;
// an independent monitor consumes them as the DUT presents them.
module tb_ldpc_serial_port;

    localparam int NN    = 208;
    localparam int CH    = 2;
    localparam int SEL_W = 16;
    localparam int CW    = 1;

    logic             clk;
    logic             rst_n;
    logic             P_start, P_inputnoutput, P_strobe, P_input;
    logic [SEL_W-1:0] P_in_out_sel, P_len;
    logic [CW-1:0]    P_chan;
    logic             PO_output, PO_busy, PO_done, PO_err;
    logic             core_wr_en, core_wr_ready;
    logic [CW-1:0]    core_wr_chan, core_rd_chan;
    logic [NN-1:0]    core_wr_data, core_rd_data;
    logic [CH-1:0]    buf_valid, core_ack;

    ldpc_serial_port #(.NN(NN), .CH(CH), .SEL_W(SEL_W)) dut (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n),
        .P_start(P_start), .P_inputnoutput(P_inputnoutput),
        .P_in_out_sel(P_in_out_sel), .P_len(P_len), .P_chan(P_chan),
        .P_strobe(P_strobe), .P_input(P_input),
        .PO_output(PO_output), .PO_busy(PO_busy), .PO_done(PO_done), .PO_err(PO_err),
        .core_wr_en(core_wr_en), .core_wr_chan(core_wr_chan), .core_wr_data(core_wr_data),
        .core_wr_ready(core_wr_ready), .core_rd_chan(core_rd_chan), .core_rd_data(core_rd_data),
        .buf_valid(buf_valid), .core_ack(core_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model
    logic [NN-1:0] mem [CH];
    logic [CH-1:0] valid_m;
    int            done_q[$];
    int            err_q[$];
    bit            bit_q[$];
    bit            unload_active;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic chkw(input string name, input logic [NN-1:0] act, input logic [NN-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk_empty(input string name, input int n);
        checks++;
        if (n != 0) begin
            failures++;
            $display("FAIL %s: actual=%0d outstanding expected pulses required=0", name, n);
        end
    endtask

    // Monitor: consumes expected pulses/bits as the DUT presents them.
    initial begin
        bit pend;
        bit exp_bit;
        pend = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                pend = 1'b0;
            end else begin
                if (pend) begin
                    if (bit_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unload_bit: actual=%b with no bit expected", PO_output);
                    end else begin
                        exp_bit = bit_q.pop_front();
                        chk1("unload_bit", PO_output, exp_bit);
                    end
                end
                if (PO_done === 1'b1) begin
                    checks++;
                    if (done_q.size() == 0) begin
                        failures++;
                        $display("FAIL po_done: actual=1 required=0 (unexpected pulse)");
                    end else begin
                        void'(done_q.pop_front());
                    end
                end
                if (PO_err === 1'b1) begin
                    checks++;
                    if (err_q.size() == 0) begin
                        failures++;
                        $display("FAIL po_err: actual=1 required=0 (unexpected pulse)");
                    end else begin
                        void'(err_q.pop_front());
                    end
                end
                pend = (P_strobe === 1'b1) && (PO_busy === 1'b1) && unload_active;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_model();
        for (int c = 0; c < CH; c++) begin
            core_rd_chan = CW'(c);
            #1;
            chkw($sformatf("rd_data_ch%0d", c), core_rd_data, mem[c]);
        end
        chkw("buf_valid", NN'(buf_valid), NN'(valid_m));
    endtask

    task automatic core_write(input int chan, input logic [NN-1:0] data);
        core_wr_en   = 1'b1;
        core_wr_chan = CW'(chan);
        core_wr_data = data;
        #1;
        chk1("wr_ready_idle", core_wr_ready, 1'b1);
        tick();
        core_wr_en = 1'b0;
        mem[chan]  = data;
    endtask

    task automatic do_ack(input logic [CH-1:0] mask);
        core_ack = mask;
        tick();
        core_ack = '0;
        valid_m  = valid_m & ~mask;
    endtask

    // opt: 0 plain, 1 alternating 1,0 data with no gaps, 2 start+core writes during load,
    //      3 core_ack at DONE, 4 start during DONE, 5 reset after 50 strobes
    task automatic do_frame(input bit load, input int chan, input int sel, input int len, input int opt);
        bit accept;
        int idx, left, n, other;
        logic [NN-1:0] rnd;
        accept = (len != 0) && (sel + len <= NN) && (chan < CH);
        other  = (chan + 1) % CH;
        P_start        = 1'b1;
        P_inputnoutput = load;
        P_in_out_sel   = SEL_W'(sel);
        P_len          = SEL_W'(len);
        P_chan         = CW'(chan);
        if (!accept) err_q.push_back(1);
        unload_active = accept && !load;
        tick();
        P_start      = 1'b0;
        P_in_out_sel = SEL_W'($urandom);
        P_len        = SEL_W'($urandom);
        chk1("busy_after_start", PO_busy, accept);
        if (!accept) begin
            tick();
            chk_empty("err_pulse", err_q.size());
            chk1("busy_after_reject", PO_busy, 1'b0);
            $display("frame load=%0d ch=%0d sel=%0d len=%0d rejected", load, chan, sel, len);
            return;
        end
        idx = sel; left = len; n = 0;
        while (left > 0) begin
            P_start    = 1'b0;
            core_wr_en = 1'b0;
            if (opt == 5 && n == 50) begin
                rst_n    = 1'b0;
                P_strobe = 1'b0;
                #1;
                chk1("rst_output", PO_output, 1'b0);
                chk1("rst_busy", PO_busy, 1'b0);
                chk1("rst_done", PO_done, 1'b0);
                chk1("rst_err", PO_err, 1'b0);
                for (int c = 0; c < CH; c++) mem[c] = '0;
                valid_m = '0;
                bit_q.delete();
                unload_active = 1'b0;
                check_model();
                tick();
                rst_n = 1'b1;
                $display("frame load=%0d ch=%0d sel=%0d len=%0d aborted by reset after 50 bits", load, chan, sel, len);
                return;
            end
            P_strobe = (opt == 1 || opt == 5) ? 1'b1 : 1'($urandom_range(0, 3) != 0);
            P_input  = 1'($urandom);
            if (P_strobe) begin
                if (load) begin
                    if (opt == 1) P_input = 1'(n % 2 == 0);
                    mem[chan][idx] = P_input;
                end else begin
                    bit_q.push_back(mem[chan][idx]);
                end
                if (left == 1) done_q.push_back(1);
            end
            if (opt == 2 && n == len / 4 && CH > 1) begin
                rnd = {7{$urandom}};
                core_wr_en   = 1'b1;
                core_wr_chan = CW'(other);
                core_wr_data = rnd;
                #1;
                chk1("wr_ready_other", core_wr_ready, 1'b1);
                mem[other] = rnd;
            end
            if (opt == 2 && n == len / 2) begin
                P_start        = 1'b1;
                P_inputnoutput = 1'($urandom);
                P_chan         = CW'($urandom);
                P_in_out_sel   = '0;
                P_len          = SEL_W'(1);
                err_q.push_back(1);
                core_wr_en   = 1'b1;
                core_wr_chan = CW'(chan);
                core_wr_data = {7{$urandom}};
                #1;
                chk1("wr_ready_active", core_wr_ready, 1'b0);
            end
            tick();
            if (P_strobe) begin
                idx++; left--; n++;
            end
        end
        // DONE cycle
        P_start    = 1'b0;
        core_wr_en = 1'b0;
        P_strobe   = 1'b0;
        chk1("done_state", PO_done, 1'b1);
        if (opt == 3) core_ack = CH'(1) << chan;
        if (opt == 4) begin
            P_start = 1'b1;
            P_len   = SEL_W'(1);
            err_q.push_back(1);
        end
        valid_m = valid_m & ~core_ack;
        if (load) valid_m[chan] = 1'b1;
        tick();
        core_ack = '0;
        P_start  = 1'b0;
        unload_active = 1'b0;
        chk1("idle_busy", PO_busy, 1'b0);
        tick();
        chk_empty("done_pulse", done_q.size());
        chk_empty("err_pulse", err_q.size());
        chk_empty("unload_bits", bit_q.size());
        check_model();
        $display("frame load=%0d ch=%0d sel=%0d len=%0d opt=%0d complete", load, chan, sel, len, opt);
    endtask

    logic [NN-1:0] alt;

    initial begin
        rst_n = 1'b0;
        P_start = 1'b0; P_inputnoutput = 1'b0; P_strobe = 1'b0; P_input = 1'b0;
        P_in_out_sel = '0; P_len = '0; P_chan = '0;
        core_wr_en = 1'b0; core_wr_chan = '0; core_wr_data = '0;
        core_rd_chan = '0; core_ack = '0;
        unload_active = 1'b0;
        for (int c = 0; c < CH; c++) mem[c] = '0;
        valid_m = '0;
        repeat (3) tick();
        chk1("reset_output", PO_output, 1'b0);
        chk1("reset_busy", PO_busy, 1'b0);
        chk1("reset_done", PO_done, 1'b0);
        chk1("reset_err", PO_err, 1'b0);
        check_model();
        rst_n = 1'b1;
        tick();

        // Full-length alternating load on channel 1
        do_frame(1'b1, 1, 0, 208, 1);
        alt = {52{4'h5}};
        core_rd_chan = 1'b1;
        #1;
        chkw("alt_pattern", core_rd_data, alt);
        chkw("alt_valid", NN'(buf_valid), NN'(2'b10));

        // Unload a known bit
        core_write(0, NN'(1) << 5);
        do_frame(1'b0, 0, 3, 4, 0);

        // Range boundaries
        do_frame(1'b1, 0, 200, 9, 0);
        do_frame(1'b1, 0, 200, 8, 0);
        do_frame(1'b0, 0, 5, 0, 0);
        do_frame(1'b0, 1, 207, 1, 0);
        do_frame(1'b0, 1, 208, 1, 0);

        // Collisions, ack/done race, start in DONE, reset abort
        do_frame(1'b1, 1, 10, 40, 2);
        do_frame(1'b1, 0, 0, 16, 3);
        do_frame(1'b0, 1, 5, 10, 4);
        do_frame(1'b1, 0, 0, 100, 5);
        do_frame(1'b1, 1, 0, 20, 0);

        // Random traffic
        for (int t = 0; t < 40; t++) begin
            int s, l;
            s = int'($urandom_range(0, NN - 1));
            l = int'($urandom_range(0, 40));
            if ($urandom_range(0, 3) == 0) core_write(int'($urandom_range(0, CH - 1)), {7{$urandom}});
            if ($urandom_range(0, 3) == 0) do_ack(CH'($urandom));
            do_frame(1'($urandom), int'($urandom_range(0, CH - 1)), s, l, int'($urandom_range(0, 4)) == 0 ? 3 : 0);
        end

        chk_empty("final_queues", done_q.size() + err_q.size() + bit_q.size());
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ldpc_serial_port.md
LDPC_SERIAL_PORT -- requirements
Module: ldpc_serial_port

Interface
REQ-001 Parameter NN, default 208 ('h d0): codeword length in bits, i.e. bits per channel buffer.
REQ-002 Parameter CH, default 2: number of independent codeword buffers (channels), CH>=1.
REQ-003 Parameter SEL_W, default 16: width of bit index and length fields; SEL_W SHALL be large enough to encode NN.
REQ-004 Local CW = max(1, clog2(CH)).
REQ-005 wb_clk_i  in  1  sole clock; all state changes on rising edge.
REQ-006 wb_rst_n_i  in  1  reset, asynchronous assert, active-low.
REQ-007 P_start  in  1  one-cycle request to begin a serial frame.
REQ-008 P_inputnoutput  in  1  frame mode, sampled with P_start: 1 = load (pin->buffer), 0 = unload (buffer->pin).
REQ-009 P_in_out_sel  in  SEL_W  start bit index, sampled with P_start.
REQ-010 P_len  in  SEL_W  frame length in bits, sampled with P_start.
REQ-011 P_chan  in  CW  target channel, sampled with P_start.
REQ-012 P_strobe  in  1  bit qualifier; one bit transferred per cycle with P_strobe=1 while busy.
REQ-013 P_input  in  1  serial load data, valid with P_strobe.
REQ-014 PO_output  out  1  registered serial unload data.
REQ-015 PO_busy  out  1  high in LOAD or UNLOAD.
REQ-016 PO_done  out  1  one-cycle frame-complete pulse.
REQ-017 PO_err  out  1  one-cycle rejected-request pulse.
REQ-018 core_wr_en / core_wr_chan / core_wr_data  in  1/CW/NN  parallel buffer write from decoder core.
REQ-019 core_wr_ready  out  1  combinational; 0 when PO_busy and core_wr_chan equals the active channel.
REQ-020 core_rd_chan  in  CW; core_rd_data  out  NN  combinational read of the selected buffer.
REQ-021 buf_valid  out  CH  per-channel flag: loaded codeword awaiting the core.
REQ-022 core_ack  in  CH  per-channel clear of buf_valid.

Function
REQ-023 FSM states: IDLE, LOAD, UNLOAD, DONE; DONE lasts exactly one cycle, then IDLE.
REQ-024 IDLE + P_start: the request SHALL be rejected if P_len==0, P_in_out_sel+P_len>NN (computed at SEL_W+1 bits), or P_chan>=CH; reject = PO_err pulse next cycle, FSM stays IDLE.
REQ-025 A valid request SHALL capture mode, channel, index=P_in_out_sel and count=P_len, then enter LOAD or UNLOAD next cycle.
REQ-026 LOAD, P_strobe=1: buffer[chan][index] <= P_input; index+1; count-1.
REQ-027 UNLOAD, P_strobe=1: PO_output <= buffer[chan][index] on that edge (1-cycle latency); index+1; count-1; PO_output holds its value otherwise.
REQ-028 Bits SHALL be transferred LSB-index first; cycles with P_strobe=0 SHALL not advance.
REQ-029 Strobe taking count to 0 SHALL move the FSM to DONE; PO_done=1 in DONE.
REQ-030 Leaving a LOAD frame via DONE SHALL set buf_valid[chan]; UNLOAD SHALL not change buf_valid.
REQ-031 P_start while busy or in DONE SHALL be ignored with a PO_err pulse; the active frame continues.
REQ-032 core_wr_en with core_wr_ready=1 SHALL overwrite the whole NN-bit buffer; with core_wr_ready=0 it SHALL be dropped.
REQ-033 core_ack[c] SHALL clear buf_valid[c]; a same-cycle set from DONE on channel c SHALL win.
REQ-034 Index never exceeds NN-1 within an accepted frame; no wrap-around occurs.

Reset
REQ-035 wb_rst_n_i=0 SHALL immediately force IDLE, clear all buffers, index, count and buf_valid, and drive PO_output, PO_busy, PO_done, PO_err to 0.
REQ-036 Reset mid-frame SHALL abort the frame with no PO_done, no buf_valid set; first accepted P_start is one cycle after deassertion.

Verification
REQ-037 Load ch1, sel=0, len=208, P_input alternating 1,0 -> PO_done after 208th strobe, buf_valid=2'b10, core_rd_data(ch1)=208'h...5555.
REQ-038 Unload ch0 after core write 208'h1 shifted left by 5, sel=3, len=4 -> PO_output sequence 0,0,1,0, PO_done once, buf_valid unchanged.
REQ-039 P_start with sel=200, len=9 -> PO_err pulse, PO_busy stays 0; sel=200, len=8 -> accepted.
REQ-040 P_start during LOAD, and core write to active channel -> PO_err pulse, core_wr_ready=0, write dropped, frame completes intact.
REQ-041 core_ack[0] in same cycle as DONE of ch0 load -> buf_valid[0]=1.
REQ-042 Reset asserted after 50 load strobes -> all outputs 0, buffer cleared, no PO_done; new frame accepted after release.
